instr_encoder: RTL and testbench
================================

Name: instr_encoder

Overview:
- Field-to-word RV32I instruction encoder; the inverse of the control/decode unit.
- Accepts decoded fields (format, opcode, rd, funct3, funct7, rs1, rs2, imm) over a valid/ready handshake and packs them into a 32-bit instruction word.
- Tags each word with a sequential instruction-memory address and buffers the results in a small FIFO toward the instruction-memory loader.
- Used by the program loader and by the decode-unit round-trip self-test.

Parameters:
- ADDR_W, 32, width of the output address and the address counter.
- BASE_ADDR, 0, address given to the first word after reset.
- FIFO_DEPTH, 4, number of output buffer entries; power of two, at least 2.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  field set presented.
- in_ready  out  1  encoder can accept; equals !fifo_full.
- fmt  in  3  0=R, 1=I, 2=S, 3=B, 4=U, 5=J, 6=SYS, 7=reserved.
- opcode  in  7  opcode field; ignored for SYS.
- rd  in  5  destination register.
- funct3  in  3  funct3 field.
- funct7  in  7  funct7 field; used by R only.
- rs1  in  5  source register 1.
- rs2  in  5  source register 2.
- imm  in  32  immediate, as the decoder produces it (sign-extended, byte offset for B/J, upper-aligned for U).
- out_valid  out  1  FIFO non-empty.
- out_ready  in  1  consumer accepts the head entry.
- out_instr  out  32  encoded word at the FIFO head.
- out_addr  out  ADDR_W  address of out_instr.
- err  out  1  sticky encode error.
- err_clr  in  1  synchronous clear of err.
- count  out  16  number of words accepted since reset; wraps.

Behaviour:
- Reset values: out_valid=0, FIFO empty, out_instr=0, out_addr=0, address counter=BASE_ADDR, err=0, count=0. in_ready=1 once reset is released.
- Accept: an input is accepted in a cycle where in_valid and in_ready are both high. On acceptance:
  - the encoded word and the current address counter are written into the FIFO tail;
  - the address counter increments by 4, modulo 2^ADDR_W;
  - count increments by 1.
- Latency: a word accepted in cycle N is visible at out_* in cycle N+1 if the FIFO was empty. Output is registered; there is no combinational path from inputs to out_*.
- Pop: the head is removed in a cycle where out_valid and out_ready are both high. The next entry appears in the following cycle.
- Simultaneous push and pop:
  - Allowed whenever in_ready=1; occupancy is unchanged.
  - When the FIFO is full, in_ready=0 in that cycle even if a pop occurs (no same-cycle full bypass).
  - When the FIFO is empty, a push and a pop in the same cycle are impossible because out_valid=0.
- Packing (bit ranges high to low):
  - R: {funct7, rs2, rs1, funct3, rd, opcode}.
  - I: {imm[11:0], rs1, funct3, rd, opcode}.
  - S: {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}.
  - B: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode}.
  - U: {imm[31:12], rd, opcode}.
  - J: {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode}.
  - SYS: I packing with the opcode forced to 7'h73.
  - fmt=7: the word is replaced by NOP 32'h00000013 and err is set.
- Pointer wrap: the FIFO read and write pointers wrap at FIFO_DEPTH. Full/empty are distinguished with an extra pointer bit.
- err: set in the cycle after an errored acceptance. It stays set until err_clr. When a set event and err_clr occur in the same cycle, the set wins.
- Reset mid-operation: FIFO contents are discarded, the address counter returns to BASE_ADDR, and out_valid drops immediately (asynchronously).

Optional Feature:
- Macro: INSTR_ENC_RANGE_CHECK_EN.
- Defined: the immediate is range-checked per format:
  - I/S/SYS: imm[31:11] all equal.
  - B: imm[31:12] all equal and imm[0]=0.
  - J: imm[31:20] all equal and imm[0]=0.
  - U: imm[11:0]=0.
  - R: no check.
  - On a violation, NOP 32'h00000013 is emitted at the normal address and err is set.
- Not defined: immediates are truncated to the packed bits without any check. err is set only by fmt=7.

Test Plan:
- Single I-type: fmt=I, opcode=0x13, rd=1, funct3=0, rs1=0, imm=5, out_ready=1 -> next cycle out_instr=0x00500093, out_addr=0, count=1.
- Branch and jump: B with opcode 0x63, rs1=1, rs2=2, imm=0xFFFFFFF8 -> 0xFE208CE3 at addr 0. Then J with opcode 0x6F, rd=1, imm=0x800 -> 0x001000EF at addr 4. Then U with opcode 0x37, rd=5, imm=0x12345000 -> 0x123452B7 at addr 8.
- Range error (macro defined): I-type with imm=2048 -> out_instr=0x00000013, err=1; err stays 1 until an err_clr pulse, then 0.
- Backpressure (FIFO_DEPTH=4): out_ready=0, in_valid held for 5 words -> in_ready=0 after 4 acceptances. Then out_ready=1 -> words drain in order at addresses 0, 4, 8, 0xC, and the 5th word is accepted with addr 0x10.
- Reset mid-operation: 2 entries buffered, rst pulsed -> out_valid=0 immediately. The next accepted word gets out_addr=BASE_ADDR and count=1.
- Reserved format: fmt=7 -> out_instr=0x00000013 and err=1, with or without the macro.

Source files
------------

// File: rtl/instr_encoder.sv
// instr_encoder: RV32I field-to-word encoder with address tagging and output FIFO (range check under INSTR_ENC_RANGE_CHECK_EN)
module instr_encoder #(
  parameter int                ADDR_W     = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR  = '0,
  parameter int                FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        fmt,
  input  logic [6:0]        opcode,
  input  logic [4:0]        rd,
  input  logic [2:0]        funct3,
  input  logic [6:0]        funct7,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  input  logic [31:0]       imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_addr,
  output logic              err,
  input  logic              err_clr,
  output logic [15:0]       count
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [31:0] NOP = 32'h0000_0013;
  logic [PW:0]        wr_q, rd_q;
  logic [31:0]        imem_q [FIFO_DEPTH];
  logic [ADDR_W-1:0]  amem_q [FIFO_DEPTH];
  logic [ADDR_W-1:0]  addr_q;
  logic [15:0]        cnt_q;
  logic               err_q;
  logic               full, empty, push, pop, range_bad, bad;
  logic [31:0]        packed_w, word_d;
  assign full      = (wr_q ^ rd_q) == {1'b1, {PW{1'b0}}};
  assign empty     = wr_q == rd_q;
  assign in_ready  = ~full;
  assign out_valid = ~empty;
  assign push      = in_valid & ~full;
  assign pop       = out_valid & out_ready;
  assign out_instr = imem_q[rd_q[PW-1:0]];
  assign out_addr  = amem_q[rd_q[PW-1:0]];
  assign err       = err_q;
  assign count     = cnt_q;
`ifdef INSTR_ENC_RANGE_CHECK_EN
  logic i_ok, b_ok, j_ok, u_ok;
  assign i_ok = &imm[31:11] | ~|imm[31:11];
  assign b_ok = (&imm[31:12] | ~|imm[31:12]) & ~imm[0];
  assign j_ok = (&imm[31:20] | ~|imm[31:20]) & ~imm[0];
  assign u_ok = ~|imm[11:0];
  // Immediate must be representable in the packed bits of its format
  always_comb begin
    range_bad = 1'b0;
    case (fmt)
      3'd1, 3'd2, 3'd6: range_bad = ~i_ok;
      3'd3:             range_bad = ~b_ok;
      3'd4:             range_bad = ~u_ok;
      3'd5:             range_bad = ~j_ok;
      default:          range_bad = 1'b0;
    endcase
  end
`else
  assign range_bad = 1'b0;
`endif
  // Pack the fields into the instruction word for the selected format
  always_comb begin
    packed_w = NOP;
    case (fmt)
      3'd0: packed_w = {funct7, rs2, rs1, funct3, rd, opcode};
      3'd1: packed_w = {imm[11:0], rs1, funct3, rd, opcode};
      3'd2: packed_w = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
      3'd3: packed_w = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
      3'd4: packed_w = {imm[31:12], rd, opcode};
      3'd5: packed_w = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
      3'd6: packed_w = {imm[11:0], rs1, funct3, rd, 7'h73};
      default: packed_w = NOP;
    endcase
  end
  assign bad    = (fmt == 3'd7) | range_bad;
  assign word_d = bad ? NOP : packed_w;
  // FIFO storage: word and its address written together at the tail
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        imem_q[i] <= '0;
        amem_q[i] <= '0;
      end
    end else if (push) begin
      imem_q[wr_q[PW-1:0]] <= word_d;
      amem_q[wr_q[PW-1:0]] <= addr_q;
    end
  end
  // Pointers, address counter, accept counter and sticky error (set beats clear)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q   <= '0;
      rd_q   <= '0;
      addr_q <= BASE_ADDR;
      cnt_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      wr_q   <= push ? wr_q + 1'b1 : wr_q;
      rd_q   <= pop ? rd_q + 1'b1 : rd_q;
      addr_q <= push ? addr_q + ADDR_W'(4) : addr_q;
      cnt_q  <= push ? cnt_q + 16'd1 : cnt_q;
      err_q  <= (push & bad) ? 1'b1 : err_clr ? 1'b0 : err_q;
    end
  end
endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: directed + random scoreboard bench for instr_encoder
module tb_instr_encoder;
  logic        clk = 0, rst = 1, in_valid = 0, out_ready = 0, err_clr = 0;
  logic [2:0]  fmt = 0, funct3 = 0;
  logic [6:0]  opcode = 0, funct7 = 0;
  logic [4:0]  rd = 0, rs1 = 0, rs2 = 0;
  logic [31:0] imm = 0;
  logic        in_ready, out_valid, err;
  logic [31:0] out_instr, out_addr;
  logic [15:0] count;
  int          total = 0, bad = 0;
  logic [63:0] sb[$];
  logic [31:0] exp_addr = 0;
  logic [15:0] exp_count = 0;
  logic        rnd_en = 0;
`ifdef INSTR_ENC_RANGE_CHECK_EN
  localparam bit RC = 1'b1;
`else
  localparam bit RC = 1'b0;
`endif

  instr_encoder dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .fmt(fmt), .opcode(opcode), .rd(rd), .funct3(funct3), .funct7(funct7),
    .rs1(rs1), .rs2(rs2), .imm(imm), .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_addr(out_addr), .err(err), .err_clr(err_clr), .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [32:0] model(input logic [2:0] f, input logic [6:0] op,
      input logic [4:0] d, input logic [2:0] f3, input logic [6:0] f7,
      input logic [4:0] s1, input logic [4:0] s2, input logic [31:0] im);
    logic [31:0] w;
    logic e;
    e = 0;
    case (f)
      0: w = {f7, s2, s1, f3, d, op};
      1: w = {im[11:0], s1, f3, d, op};
      2: w = {im[11:5], s2, s1, f3, im[4:0], op};
      3: w = {im[12], im[10:5], s2, s1, f3, im[4:1], im[11], op};
      4: w = {im[31:12], d, op};
      5: w = {im[20], im[10:1], im[11], im[19:12], d, op};
      6: w = {im[11:0], s1, f3, d, 7'h73};
      default: begin w = 32'h13; e = 1; end
    endcase
    if (RC) begin
      if ((f == 1 || f == 2 || f == 6) && !(im[31:11] == '0 || im[31:11] == '1)) e = 1;
      if (f == 3 && (!(im[31:12] == '0 || im[31:12] == '1) || im[0])) e = 1;
      if (f == 5 && (!(im[31:20] == '0 || im[31:20] == '1) || im[0])) e = 1;
      if (f == 4 && im[11:0] != 0) e = 1;
    end
    return {e, e ? 32'h13 : w};
  endfunction

  // Scoreboard: compare the head on each pop, then record each accepted input
  always @(negedge clk) if (!rst) begin
    logic [63:0] e;
    logic [32:0] m;
    if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        total++; bad++;
        $error("FAIL sb_underflow got=%h exp=none", out_instr);
      end else begin
        e = sb.pop_front();
        chk("sb_instr", {32'd0, out_instr}, {32'd0, e[31:0]});
        chk("sb_addr", {32'd0, out_addr}, {32'd0, e[63:32]});
      end
    end
    if (in_valid && in_ready) begin
      m = model(fmt, opcode, rd, funct3, funct7, rs1, rs2, imm);
      sb.push_back({exp_addr, m[31:0]});
      exp_addr += 4;
      exp_count++;
    end
  end

  always begin
    @(posedge clk); #1;
    if (rnd_en) out_ready = 1'($urandom_range(0, 1));
  end

  task automatic send(input logic [2:0] f, input logic [6:0] op, input logic [4:0] d,
      input logic [2:0] f3, input logic [6:0] f7, input logic [4:0] s1,
      input logic [4:0] s2, input logic [31:0] im);
    logic ok;
    fmt = f; opcode = op; rd = d; funct3 = f3; funct7 = f7; rs1 = s1; rs2 = s2; imm = im;
    in_valid = 1;
    ok = 0;
    for (int k = 0; k < 60 && !ok; k++) begin
      @(negedge clk); ok = in_ready;
      @(posedge clk); #1;
    end
    in_valid = 0;
    if (!ok) begin
      total++; bad++;
      $error("FAIL send_timeout got=0 exp=1");
    end
  endtask

  task automatic do_reset();
    rst = 1;
    sb.delete();
    exp_addr = 0;
    exp_count = 0;
    @(posedge clk); #1;
    rst = 0;
  endtask

  task automatic drain();
    for (int k = 0; k < 200 && sb.size() != 0; k++) @(posedge clk);
    #1;
    chk("drain_empty", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    #2;
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_out_instr", {32'd0, out_instr}, 64'd0);
    chk("rst_out_addr", {32'd0, out_addr}, 64'd0);
    chk("rst_err", {63'd0, err}, 64'd0);
    chk("rst_count", {48'd0, count}, 64'd0);
    @(posedge clk); #1;
    rst = 0;
    @(negedge clk);
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    @(posedge clk); #1;
    out_ready = 1;
    send(1, 7'h13, 1, 0, 0, 0, 0, 32'd5);
    @(negedge clk);
    chk("i_instr", {32'd0, out_instr}, 64'h00500093);
    chk("i_addr", {32'd0, out_addr}, 64'd0);
    chk("i_count", {48'd0, count}, 64'd1);
    @(posedge clk); #1;
    do_reset();
    send(3, 7'h63, 0, 0, 0, 1, 2, 32'hFFFFFFF8);
    @(negedge clk);
    chk("b_instr", {32'd0, out_instr}, 64'hFE208CE3);
    chk("b_addr", {32'd0, out_addr}, 64'd0);
    @(posedge clk); #1;
    send(5, 7'h6F, 1, 0, 0, 0, 0, 32'h800);
    @(negedge clk);
    chk("j_instr", {32'd0, out_instr}, 64'h001000EF);
    chk("j_addr", {32'd0, out_addr}, 64'd4);
    @(posedge clk); #1;
    send(4, 7'h37, 5, 0, 0, 0, 0, 32'h12345000);
    @(negedge clk);
    chk("u_instr", {32'd0, out_instr}, 64'h123452B7);
    chk("u_addr", {32'd0, out_addr}, 64'd8);
    @(posedge clk); #1;
    do_reset();
    send(1, 7'h13, 1, 0, 0, 0, 0, 32'd2048);
    @(negedge clk);
    chk("range_instr", {32'd0, out_instr}, RC ? 64'h13 : 64'h80000093);
    chk("range_err", {63'd0, err}, {63'd0, RC});
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("range_err_hold", {63'd0, err}, {63'd0, RC});
    @(posedge clk); #1;
    send(7, 7'h33, 3, 1, 7'h20, 4, 5, 32'd0);
    @(negedge clk);
    chk("resv_instr", {32'd0, out_instr}, 64'h13);
    chk("resv_err", {63'd0, err}, 64'd1);
    @(posedge clk); #1;
    err_clr = 1;
    @(posedge clk); #1;
    err_clr = 0;
    @(negedge clk);
    chk("err_clr", {63'd0, err}, 64'd0);
    @(posedge clk); #1;
    err_clr = 1;
    send(7, 7'h00, 0, 0, 0, 0, 0, 32'd0);
    err_clr = 0;
    @(negedge clk);
    chk("err_set_wins", {63'd0, err}, 64'd1);
    @(posedge clk); #1;
    err_clr = 1;
    @(posedge clk); #1;
    err_clr = 0;
    do_reset();
    out_ready = 0;
    send(0, 7'h33, 3, 0, 7'h20, 1, 2, 32'd0);
    send(2, 7'h23, 0, 2, 0, 8, 9, 32'hFFFFFFFC);
    send(1, 7'h03, 7, 4, 0, 3, 0, 32'h000007FF);
    send(6, 7'h00, 0, 0, 0, 0, 0, 32'd1);
    @(negedge clk);
    chk("bp_in_ready", {63'd0, in_ready}, 64'd0);
    chk("bp_count", {48'd0, count}, 64'd4);
    chk("bp_head_addr", {32'd0, out_addr}, 64'd0);
    @(posedge clk); #1;
    fmt = 4; opcode = 7'h17; rd = 10; imm = 32'hABCDE000; in_valid = 1; out_ready = 1;
    @(negedge clk);
    chk("bp_no_bypass", {63'd0, in_ready}, 64'd0);
    @(posedge clk); #1;
    send(4, 7'h17, 10, 0, 0, 0, 0, 32'hABCDE000);
    drain();
    chk("bp_exp_addr", {32'd0, exp_addr}, 64'h14);
    out_ready = 0;
    send(1, 7'h13, 2, 0, 0, 2, 0, 32'd1);
    send(1, 7'h13, 3, 0, 0, 3, 0, 32'd2);
    @(negedge clk);
    chk("mid_valid", {63'd0, out_valid}, 64'd1);
    #2 rst = 1;
    #1;
    chk("mid_async_valid", {63'd0, out_valid}, 64'd0);
    sb.delete();
    exp_addr = 0;
    exp_count = 0;
    @(posedge clk); #1;
    rst = 0;
    out_ready = 1;
    send(0, 7'h33, 1, 0, 0, 1, 1, 32'd0);
    @(negedge clk);
    chk("mid_addr", {32'd0, out_addr}, 64'd0);
    chk("mid_count", {48'd0, count}, 64'd1);
    @(posedge clk); #1;
    rnd_en = 1;
    for (int i = 0; i < 24; i++) begin
      logic [31:0] r;
      r = $urandom;
      if (i % 2 == 0) r = {{20{r[11]}}, r[11:1], 1'b0};
      send(3'($urandom_range(0, 6)), 7'($urandom), 5'($urandom), 3'($urandom),
           7'($urandom), 5'($urandom), 5'($urandom), r);
    end
    rnd_en = 0;
    #2 out_ready = 1;
    drain();
    @(negedge clk);
    chk("rand_count", {48'd0, count}, {48'd0, exp_count});
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
